pong_match_ctrl: RTL

Match-sequencing controller for the pong game: a Moore state machine that owns the serve/play/point/game-over flow. It drives the `en` of both paddle state blocks and the enable/reset of the ball block. It consumes miss strobes from the ball logic and keeps both scores. It sits between the player-input blocks and the ball/display datapath, clocked by the system `clk`.

---
 rtl/pong_match_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pong_match_ctrl.sv
// Match-sequencing controller for pong: serve/play/point/game-over Moore FSM owning both scores.
// Optional pause support is compiled in when PONG_PAUSE_EN is defined.
module pong_match_ctrl #(
    parameter int WIN_SCORE   = 5,
    parameter int SCORE_WIDTH = 3,
    parameter int SERVE_TICKS = 60,
    parameter int POINT_TICKS = 30,
    parameter int TICK_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   frame_tick,
    input  logic                   miss_left,
    input  logic                   miss_right,
`ifdef PONG_PAUSE_EN
    input  logic                   pause,
`endif
    output logic                   paddle_en,
    output logic                   ball_en,
    output logic                   ball_reset,
    output logic                   serve_dir,
    output logic [SCORE_WIDTH-1:0] score_left,
    output logic [SCORE_WIDTH-1:0] score_right,
    output logic                   winner,
    output logic                   game_over,
    output logic [2:0]             state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4,
        PAUSE = 3'd5
    } state_t;

    localparam logic [TICK_WIDTH-1:0]  SERVE_LOAD = TICK_WIDTH'(SERVE_TICKS);
    localparam logic [TICK_WIDTH-1:0]  POINT_LOAD = TICK_WIDTH'(POINT_TICKS);
    localparam logic [SCORE_WIDTH-1:0] WIN_VAL    = SCORE_WIDTH'(WIN_SCORE);

    state_t                   state_reg, state_next;
    logic [TICK_WIDTH-1:0]    cnt_reg, cnt_next;
    logic [SCORE_WIDTH-1:0]   score_left_reg, score_left_next;
    logic [SCORE_WIDTH-1:0]   score_right_reg, score_right_next;
    logic                     serve_dir_reg, serve_dir_next;
    logic                     winner_reg, winner_next;
    logic                     start_q_reg;
    logic                     start_rise;
    logic [3:0]               flags_reg;   // {paddle_en, ball_en, ball_reset, game_over}
    logic [SCORE_WIDTH-1:0]   score_left_inc, score_right_inc;
    logic                     cnt_last;

    assign start_rise      = start & ~start_q_reg;
    assign score_left_inc  = score_left_reg + SCORE_WIDTH'(1);
    assign score_right_inc = score_right_reg + SCORE_WIDTH'(1);
    assign cnt_last        = (cnt_reg == TICK_WIDTH'(1));

`ifdef PONG_PAUSE_EN
    logic pause_q_reg;
    logic pause_rise;
    assign pause_rise = pause & ~pause_q_reg;

    always_ff @(posedge clk) begin
        if (rst) pause_q_reg <= 1'b0;
        else     pause_q_reg <= pause;
    end
`endif

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        score_left_next  = score_left_reg;
        score_right_next = score_right_reg;
        serve_dir_next   = serve_dir_reg;
        winner_next      = winner_reg;
        case (state_reg)
            IDLE: begin
                score_left_next  = '0;
                score_right_next = '0;
                if (start_rise) begin
                    state_next = SERVE;
                    cnt_next   = SERVE_LOAD;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    if (cnt_last) state_next = PLAY;
                    else          cnt_next   = cnt_reg - TICK_WIDTH'(1);
                end
            end
            PLAY: begin
                if (miss_left && miss_right) begin
                    state_next = POINT;
                    cnt_next   = POINT_LOAD;
                end else if (miss_left) begin
                    score_right_next = score_right_inc;
                    serve_dir_next   = 1'b0;
                    if (score_right_inc == WIN_VAL) begin
                        state_next  = OVER;
                        winner_next = 1'b1;
                    end else begin
                        state_next = POINT;
                        cnt_next   = POINT_LOAD;
                    end
                end else if (miss_right) begin
                    score_left_next = score_left_inc;
                    serve_dir_next  = 1'b1;
                    if (score_left_inc == WIN_VAL) begin
                        state_next  = OVER;
                        winner_next = 1'b0;
                    end else begin
                        state_next = POINT;
                        cnt_next   = POINT_LOAD;
                    end
                end
`ifdef PONG_PAUSE_EN
                else if (pause_rise) begin
                    state_next = PAUSE;
                end
`endif
            end
            POINT: begin
                if (frame_tick) begin
                    if (cnt_last) begin
                        state_next = SERVE;
                        cnt_next   = SERVE_LOAD;
                    end else begin
                        cnt_next = cnt_reg - TICK_WIDTH'(1);
                    end
                end
            end
            OVER: begin
                if (start_rise) begin
                    state_next       = SERVE;
                    cnt_next         = SERVE_LOAD;
                    score_left_next  = '0;
                    score_right_next = '0;
                    winner_next      = 1'b0;
                end
            end
`ifdef PONG_PAUSE_EN
            PAUSE: begin
                if (pause_rise) state_next = PLAY;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            score_left_reg  <= '0;
            score_right_reg <= '0;
            serve_dir_reg   <= 1'b0;
            winner_reg      <= 1'b0;
            start_q_reg     <= 1'b0;
            flags_reg       <= 4'b0010;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            score_left_reg  <= score_left_next;
            score_right_reg <= score_right_next;
            serve_dir_reg   <= serve_dir_next;
            winner_reg      <= winner_next;
            start_q_reg     <= start;
            // Flags decoded from the next state so they line up with state_reg.
            case (state_next)
                SERVE:   flags_reg <= 4'b1010;
                PLAY:    flags_reg <= 4'b1100;
                POINT:   flags_reg <= 4'b0010;
                OVER:    flags_reg <= 4'b0011;
`ifdef PONG_PAUSE_EN
                PAUSE:   flags_reg <= 4'b1000;
`endif
                default: flags_reg <= 4'b0010;
            endcase
        end
    end

    assign state       = state_reg;
    assign score_left  = score_left_reg;
    assign score_right = score_right_reg;
    assign serve_dir   = serve_dir_reg;
    assign winner      = winner_reg;
    assign paddle_en   = flags_reg[3];
    assign ball_en     = flags_reg[2];
    assign ball_reset  = flags_reg[1];
    assign game_over   = flags_reg[0];

endmodule
